vehicle_supervisor: RTL and testbench

VEHICLE_SUPERVISOR -- requirements
Module: vehicle_supervisor

---
 rtl/vehicle_supervisor_if.sv | 26 ++
 rtl/vehicle_supervisor.sv | 52 +++++
 tb/tb_vehicle_supervisor.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vehicle_supervisor_if.sv
// vehicle_supervisor_if: operator/sensor inputs and registered supervisor outputs.
// trip_count exists only when VEHICLE_SUP_TRIP_CNT_EN is defined.
interface vehicle_supervisor_if;
    logic       start;
    logic       arrived;
    logic       gas_tank_empty;
    logic       refuel_done;
    logic       cpu_overheated;
    logic       keep_driving;
    logic       shut_off_computer;
    logic       refuel_req;
    logic       trip_done;
    logic [1:0] state;
`ifdef VEHICLE_SUP_TRIP_CNT_EN
    logic [7:0] trip_count;
    modport master (output start, arrived, gas_tank_empty, refuel_done, cpu_overheated,
                    input keep_driving, shut_off_computer, refuel_req, trip_done, state, trip_count);
    modport slave  (input start, arrived, gas_tank_empty, refuel_done, cpu_overheated,
                    output keep_driving, shut_off_computer, refuel_req, trip_done, state, trip_count);
`else
    modport master (output start, arrived, gas_tank_empty, refuel_done, cpu_overheated,
                    input keep_driving, shut_off_computer, refuel_req, trip_done, state);
    modport slave  (input start, arrived, gas_tank_empty, refuel_done, cpu_overheated,
                    output keep_driving, shut_off_computer, refuel_req, trip_done, state);
`endif
endinterface

// File: rtl/vehicle_supervisor.sv
// vehicle_supervisor: trip FSM with thermal cooldown shutdown.
// Optional saturating trip counter enabled by VEHICLE_SUP_TRIP_CNT_EN.
module vehicle_supervisor #(
    parameter int COOLDOWN_CYCLES = 16
) (
    input logic            clk,
    input logic            areset,
    vehicle_supervisor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, REFUEL, DONE} state_t;
    state_t     cur, nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       shut_nxt;
    assign bus.state = cur;
    // cooldown is nonzero whenever the alarm is sampled, so it alone drives shutdown
    always_comb begin
        cnt_nxt  = bus.cpu_overheated ? 8'(COOLDOWN_CYCLES) : (cnt != 8'd0 ? cnt - 8'd1 : 8'd0);
        shut_nxt = cnt_nxt != 8'd0;
        nxt      = cur;
        unique case (cur)
            IDLE:   nxt = (bus.start && !bus.shut_off_computer) ? DRIVE : IDLE;
            DRIVE:  nxt = bus.arrived ? DONE : bus.gas_tank_empty ? REFUEL : DRIVE;
            REFUEL: nxt = bus.arrived ? DONE : (bus.refuel_done && !bus.gas_tank_empty) ? DRIVE : REFUEL;
            DONE:   nxt = bus.start ? DONE : IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cur                   <= IDLE;
            cnt                   <= 8'd0;
            bus.keep_driving      <= 1'b0;
            bus.shut_off_computer <= 1'b0;
            bus.refuel_req        <= 1'b0;
            bus.trip_done         <= 1'b0;
        end else begin
            cur                   <= nxt;
            cnt                   <= cnt_nxt;
            bus.keep_driving      <= nxt == DRIVE && !shut_nxt;
            bus.shut_off_computer <= shut_nxt;
            bus.refuel_req        <= nxt == REFUEL;
            bus.trip_done         <= nxt == DONE;
        end
    end
`ifdef VEHICLE_SUP_TRIP_CNT_EN
    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            bus.trip_count <= 8'd0;
        else if (nxt == DONE && cur != DONE && bus.trip_count != 8'hff)
            bus.trip_count <= bus.trip_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_vehicle_supervisor.sv
// tb_vehicle_supervisor: directed stimulus, per-cycle compare against an event-level model.
// Build with VEHICLE_SUP_TRIP_CNT_EN defined to also exercise the trip counter.
module tb_vehicle_supervisor;
    localparam int C = 4;
    logic clk = 1'b0;
    logic areset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    vehicle_supervisor_if bus();
    vehicle_supervisor #(.COOLDOWN_CYCLES(C)) dut (.clk(clk), .areset(areset), .bus(bus));
    always #5 clk = ~clk;

    // model: shutdown is "fewer than C edges since the last hot edge"
    int m_state = 0, edge_n = 0, last_hot = -1000, m_trips = 0;
    bit m_shut = 0, m_kd = 0;
    always @(posedge clk or posedge areset) begin
        int ns;
        bit nshut;
        if (areset) begin
            m_state = 0; edge_n = 0; last_hot = -1000; m_trips = 0; m_shut = 0; m_kd = 0;
        end else begin
            edge_n++;
            if (bus.cpu_overheated) last_hot = edge_n;
            nshut = (edge_n - last_hot) < C;
            ns = m_state;
            if (m_state == 0 && bus.start && !m_shut) ns = 1;
            else if (m_state == 1 || m_state == 2) begin
                if (bus.arrived) ns = 3;
                else if (m_state == 1 && bus.gas_tank_empty) ns = 2;
                else if (m_state == 2 && bus.refuel_done && !bus.gas_tank_empty) ns = 1;
            end else if (m_state == 3 && !bus.start) ns = 0;
            if (ns == 3 && m_state != 3 && m_trips < 255) m_trips++;
            m_state = ns;
            m_shut = nshut;
            m_kd = ns == 1 && !nshut;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (!areset) begin
        chk("model.state", int'(bus.state), m_state);
        chk("model.keep_driving", int'(bus.keep_driving), int'(m_kd));
        chk("model.shut_off", int'(bus.shut_off_computer), int'(m_shut));
        chk("model.refuel_req", int'(bus.refuel_req), int'(m_state == 2));
        chk("model.trip_done", int'(bus.trip_done), int'(m_state == 3));
`ifdef VEHICLE_SUP_TRIP_CNT_EN
        chk("model.trip_count", int'(bus.trip_count), m_trips);
`endif
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".state"}, int'(bus.state), 0);
        chk({tag, ".keep_driving"}, int'(bus.keep_driving), 0);
        chk({tag, ".shut_off"}, int'(bus.shut_off_computer), 0);
        chk({tag, ".refuel_req"}, int'(bus.refuel_req), 0);
        chk({tag, ".trip_done"}, int'(bus.trip_done), 0);
    endtask

    task automatic trip();
        bus.start = 1; cyc();
        bus.start = 0; bus.arrived = 1; cyc();
        bus.arrived = 0; cyc();
    endtask

    initial begin
        {bus.start, bus.arrived, bus.gas_tank_empty, bus.refuel_done, bus.cpu_overheated} = '0;
        cyc(2);
        chk_all_zero("reset");
        areset = 0;
        // basic trip
        bus.start = 1; cyc();
        chk("trip.drive_state", int'(bus.state), 1);
        chk("trip.drive_kd", int'(bus.keep_driving), 1);
        bus.start = 0; bus.arrived = 1; cyc();
        chk("trip.done_state", int'(bus.state), 3);
        chk("trip.done_flag", int'(bus.trip_done), 1);
        chk("trip.done_kd", int'(bus.keep_driving), 0);
        bus.arrived = 0; cyc();
        chk("trip.idle_state", int'(bus.state), 0);
        // refuel path, refuel_done ignored while tank still empty
        bus.start = 1; cyc();
        bus.start = 0; bus.gas_tank_empty = 1; cyc();
        chk("refuel.state", int'(bus.state), 2);
        chk("refuel.req", int'(bus.refuel_req), 1);
        chk("refuel.kd", int'(bus.keep_driving), 0);
        bus.refuel_done = 1; cyc();
        chk("refuel.empty_ignored", int'(bus.state), 2);
        bus.gas_tank_empty = 0; cyc();
        chk("refuel.back_drive", int'(bus.state), 1);
        chk("refuel.back_kd", int'(bus.keep_driving), 1);
        bus.refuel_done = 0;
        // single overheat pulse in DRIVE
        bus.cpu_overheated = 1; cyc();
        bus.cpu_overheated = 0;
        chk("heat1.shut_k", int'(bus.shut_off_computer), 1);
        chk("heat1.kd_k", int'(bus.keep_driving), 0);
        cyc(3);
        chk("heat1.shut_k3", int'(bus.shut_off_computer), 1);
        chk("heat1.state_k3", int'(bus.state), 1);
        cyc();
        chk("heat1.shut_k4", int'(bus.shut_off_computer), 0);
        chk("heat1.kd_k4", int'(bus.keep_driving), 1);
        // re-assertion restarts cooldown
        bus.cpu_overheated = 1; cyc();
        bus.cpu_overheated = 0; cyc();
        bus.cpu_overheated = 1; cyc();
        bus.cpu_overheated = 0; cyc(3);
        chk("heat2.shut_k5", int'(bus.shut_off_computer), 1);
        cyc();
        chk("heat2.shut_k6", int'(bus.shut_off_computer), 0);
        // start in IDLE is blocked during shutdown
        bus.arrived = 1; cyc();
        bus.arrived = 0; cyc();
        bus.cpu_overheated = 1; cyc();
        bus.cpu_overheated = 0; bus.start = 1; cyc();
        chk("idle_heat.state_k1", int'(bus.state), 0);
        cyc(3);
        chk("idle_heat.state_k4", int'(bus.state), 0);
        chk("idle_heat.shut_k4", int'(bus.shut_off_computer), 0);
        cyc();
        chk("idle_heat.state_k5", int'(bus.state), 1);
        bus.start = 0;
        // arrived beats refuel_done in REFUEL
        bus.gas_tank_empty = 1; cyc();
        bus.arrived = 1; bus.refuel_done = 1; cyc();
        chk("prio.state", int'(bus.state), 3);
        {bus.arrived, bus.refuel_done, bus.gas_tank_empty} = '0; cyc();
        // async reset mid-trip and mid-cooldown
        bus.start = 1; cyc();
        bus.start = 0; bus.cpu_overheated = 1; cyc();
        bus.cpu_overheated = 0; cyc();
        #2 areset = 1;
        #1 chk_all_zero("areset");
        cyc();
        areset = 0;
        bus.start = 1; cyc();
        chk("post_reset.state", int'(bus.state), 1);
        chk("post_reset.kd", int'(bus.keep_driving), 1);
        bus.start = 0; cyc();
`ifdef VEHICLE_SUP_TRIP_CNT_EN
        #2 areset = 1;
        cyc();
        areset = 0;
        repeat (3) trip();
        chk("cnt.three", int'(bus.trip_count), 3);
        repeat (253) trip();
        chk("cnt.255", int'(bus.trip_count), 255);
        trip();
        chk("cnt.sat", int'(bus.trip_count), 255);
`else
        trip();
        chk("trip2.state", int'(bus.state), 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
